if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch-to-decode instruction queue for the 32-bit ARM pipeline, and the successor to the single-entry IF/ID register. It holds up to DEPTH fetched instruction/PC pairs in a circular buffer. It also supports flush, decode-side freeze and a valid/ready handshake toward fetch. The head entry is presented already split into ARM instruction fields, so the decode stage can consume it without extra slicing.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- ADDR_W, 32, PC width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch taken)
- in_valid  in  1  fetch presents instruction/pc
- in_ready  out  1  queue can accept; equals ~full (no combinational dependence on freeze)
- instruction  in  32  fetched word
- pc  in  ADDR_W  PC accompanying instruction
- freeze  in  1  decode stall; blocks pop
- out_valid  out  1  head entry valid
- cond  out  4  head[31:28]
- mode  out  2  head[27:26]
- imm  out  1  head[25]
- opCode  out  4  head[24:21]
- status  out  1  head[20]
- rn, rd  out  4 each  head[19:16], head[15:12]
- shifterOpr  out  12  head[11:0]
- signedImm24  out  24  head[23:0]
- out_pc  out  ADDR_W  PC of head entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- push = in_valid & in_ready & ~flush; pop = out_valid & ~freeze & ~flush.
- Storage: DEPTH × (32 + ADDR_W) array; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- push: write at wr_ptr, wr_ptr+1. pop: rd_ptr+1. Both: count unchanged. Push only: count+1. Pop only: count−1.
- full = (count == DEPTH); empty = (count == 0); out_valid = ~empty (unless bypass, see Configuration).
- Field outputs are combinational slices of the head entry. When out_valid = 0, all field outputs and out_pc are forced to 0.
- flush: next edge sets wr_ptr = rd_ptr = count = 0. Flush overrides a simultaneous push and pop; the incoming word is dropped.
- rst: same as flush and takes priority over it. After reset, all outputs are 0, in_ready = 1 and out_valid = 0. Storage contents need not be cleared.
- Freeze while full: in_ready = 0 and contents hold indefinitely.
- Push while full is impossible by construction. A pop while empty never occurs because out_valid gates pop.

## Timing
- Push-to-head latency: a word pushed at edge N is visible on the outputs from edge N (cycle N+1) if the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flush/reset effect is visible in the cycle after the asserting edge.
- in_ready is a registered-state function only (derived from count). out_valid depends only on state, or on in_valid under bypass.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: when empty and in_valid & ~flush, out_valid = 1 and the fields/out_pc come directly from instruction/pc in the same cycle.
  - If that bypassed word is popped in the same cycle, it is not written, and count stays 0.
  - If it is not popped, it is written normally.
- Not defined: no bypass, and the minimum latency is one cycle as above.

## Structure
- Shared package arm_pkg holds:
  - localparams for the ARM field bit positions (COND_MSB … IMM24_LSB);
  - typedef struct packed inst_fields_t {cond, mode, imm, opCode, status, rn, rd, shifterOpr, signedImm24};
  - a function that splits a 32-bit word into inst_fields_t.
- One sub-module, inst_field_split: purely combinational, 32-bit word in, inst_fields_t out. It is instantiated once on the head/bypass mux output.

## Test plan
- Reset then idle: rst = 1 for 2 cycles → count = 0, in_ready = 1, out_valid = 0, all fields 0.
- Fill with freeze = 1, DEPTH = 4: push 0xE3A01005/pc 0x00, 0xE2811001/0x04, 0xE0822001/0x08, 0xEAFFFFFE/0x0C → count = 4, in_ready = 0. Head shows cond = 0xE, imm = 1, opCode = 0xD, rd = 1, shifterOpr = 0x005, out_pc = 0.
- Release freeze with in_valid = 0 → four pops in order, out_pc sequence 0x00, 0x04, 0x08, 0x0C, then out_valid = 0. Last head signedImm24 = 0xFFFFFE.
- Simultaneous push/pop across wrap: hold count = 2 and stream 10 words with no freeze → count stays 2, output order is preserved, pointers wrap with no loss.
- Flush with count = 3, plus in_valid and pop in the same cycle → next cycle count = 0, out_valid = 0. The pushed word never appears.
- Bypass (macro defined): queue empty, push 0xE1A00000, freeze = 0 → out_valid = 1 in the same cycle, opCode = 0xD, and count remains 0. Without the macro, the same word appears one cycle later.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// ARM instruction field layout shared by the fetch-to-decode queue.
// Provides field bit positions, the split-field struct and a split helper.
package arm_pkg;

  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned MODE_MSB  = 27;
  localparam int unsigned MODE_LSB  = 26;
  localparam int unsigned IMM_BIT   = 25;
  localparam int unsigned OPC_MSB   = 24;
  localparam int unsigned OPC_LSB   = 21;
  localparam int unsigned S_BIT     = 20;
  localparam int unsigned RN_MSB    = 19;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned SHOP_MSB  = 11;
  localparam int unsigned SHOP_LSB  = 0;
  localparam int unsigned IMM24_MSB = 23;
  localparam int unsigned IMM24_LSB = 0;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  mode;
    logic        imm;
    logic [3:0]  opCode;
    logic        status;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] shifterOpr;
    logic [23:0] signedImm24;
  } inst_fields_t;

  function automatic inst_fields_t split_inst(input logic [31:0] w);
    inst_fields_t f;
    f.cond        = w[COND_MSB:COND_LSB];
    f.mode        = w[MODE_MSB:MODE_LSB];
    f.imm         = w[IMM_BIT];
    f.opCode      = w[OPC_MSB:OPC_LSB];
    f.status      = w[S_BIT];
    f.rn          = w[RN_MSB:RN_LSB];
    f.rd          = w[RD_MSB:RD_LSB];
    f.shifterOpr  = w[SHOP_MSB:SHOP_LSB];
    f.signedImm24 = w[IMM24_MSB:IMM24_LSB];
    return f;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side valid/ready channel into the instruction queue.
// master = fetch stage, slave = queue.
interface if_id_queue_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] pc;

  modport master (
    output in_valid,
    output instruction,
    output pc,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  instruction,
    input  pc,
    output in_ready
  );
endinterface

// File: rtl/if_id_queue_field_split.sv
// Purely combinational split of a 32-bit ARM word into decode fields.
module inst_field_split
  import arm_pkg::*;
(
  input  logic [31:0]  i_word,
  output inst_fields_t o_fields
);

  assign o_fields = split_inst(i_word);

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of
// instruction/PC pairs with flush, decode freeze and a valid/ready fetch port.
// Head entry is presented pre-split into ARM fields (zero when not valid).
// Optional feature: define IF_ID_QUEUE_BYPASS_EN to let an incoming word reach
// the outputs in the same cycle while the queue is empty.
module if_id_queue
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       freeze,
  if_id_queue_if.slave               fetch,
  output logic                       out_valid,
  output logic [3:0]                 cond,
  output logic [1:0]                 mode,
  output logic                       imm,
  output logic [3:0]                 opCode,
  output logic                       status,
  output logic [3:0]                 rn,
  output logic [3:0]                 rd,
  output logic [11:0]                shifterOpr,
  output logic [23:0]                signedImm24,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]       r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;
  logic              w_bypass_pop;
  logic              w_wr;
  logic              w_rd;
  logic [31:0]       w_sel_inst;
  logic [ADDR_W-1:0] w_sel_pc;
  inst_fields_t      w_fields;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & fetch.in_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign fetch.in_ready = ~w_full;
  assign out_valid      = ~w_empty | w_bypass;
  assign w_push         = fetch.in_valid & ~w_full & ~flush;
  assign w_pop          = out_valid & ~freeze & ~flush;

  // A bypassed word consumed in the same cycle never touches storage.
  assign w_bypass_pop = w_bypass & w_pop;
  assign w_wr         = w_push & ~w_bypass_pop;
  assign w_rd         = w_pop & ~w_bypass_pop;

  // Head selection: bypass word, stored head, or all-zero when nothing is valid.
  always_comb begin
    w_sel_inst = '0;
    w_sel_pc   = '0;
    if (w_bypass) begin
      w_sel_inst = fetch.instruction;
      w_sel_pc   = fetch.pc;
    end else if (!w_empty) begin
      w_sel_inst = r_mem_inst[r_rd_ptr];
      w_sel_pc   = r_mem_pc[r_rd_ptr];
    end
  end

  inst_field_split u_split (
    .i_word   (w_sel_inst),
    .o_fields (w_fields)
  );

  assign cond        = w_fields.cond;
  assign mode        = w_fields.mode;
  assign imm         = w_fields.imm;
  assign opCode      = w_fields.opCode;
  assign status      = w_fields.status;
  assign rn          = w_fields.rn;
  assign rd          = w_fields.rd;
  assign shifterOpr  = w_fields.shifterOpr;
  assign signedImm24 = w_fields.signedImm24;
  assign out_pc      = w_sel_pc;
  assign count       = r_count;

  // Storage write; contents are not cleared by reset since pointers are.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_inst[r_wr_ptr] <= fetch.instruction;
      r_mem_pc[r_wr_ptr]   <= fetch.pc;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: directed scenarios followed by random traffic,
// checked against a queue-based behavioural model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst, flush, freeze;
  logic          out_valid, imm, status;
  logic [3:0]    cond, opCode, rn, rd;
  logic [1:0]    mode;
  logic [11:0]   shifterOpr;
  logic [23:0]   signedImm24;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;

  always #5 clk = ~clk;

  if_id_queue_if #(.ADDR_W(AW)) fif ();

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .freeze      (freeze),
    .fetch       (fif),
    .out_valid   (out_valid),
    .cond        (cond),
    .mode        (mode),
    .imm         (imm),
    .opCode      (opCode),
    .status      (status),
    .rn          (rn),
    .rd          (rd),
    .shifterOpr  (shifterOpr),
    .signedImm24 (signedImm24),
    .out_pc      (out_pc),
    .count       (count)
  );

  typedef struct {
    logic [31:0]   ins;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bypass();
`ifdef IF_ID_QUEUE_BYPASS_EN
    return (q.size() == 0) && fif.in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Drive inputs after the falling edge and optionally compare all outputs.
  task automatic drive(input logic iv, input logic [31:0] ins, input logic [AW-1:0] p,
                       input logic frz, input logic fl, input logic rs, input bit do_chk);
    logic [31:0]   w;
    logic [AW-1:0] wp;
    logic          v;
    @(negedge clk);
    fif.in_valid    = iv;
    fif.instruction = ins;
    fif.pc          = p;
    freeze          = frz;
    flush           = fl;
    rst             = rs;
    #1;
    if (do_chk) begin
      w = '0; wp = '0; v = 1'b0;
      if (q.size() > 0) begin
        v = 1'b1; w = q[0].ins; wp = q[0].pc;
      end else if (model_bypass()) begin
        v = 1'b1; w = ins; wp = p;
      end
      chk("out_valid", 64'(out_valid), 64'(v));
      chk("in_ready", 64'(fif.in_ready), 64'(q.size() < DEPTH));
      chk("count", 64'(count), 64'(q.size()));
      chk("fields",
          64'({cond, mode, imm, opCode, status, rn, rd, shifterOpr, signedImm24}),
          64'({w[31:28], w[27:26], w[25], w[24:21], w[20], w[19:16], w[15:12],
               w[11:0], w[23:0]}));
      chk("out_pc", 64'(out_pc), 64'(wp));
    end
  endtask

  // Advance one edge and apply the queue rules to the model.
  task automatic commit();
    bit byp, vld, pop, acc;
    ent_t e;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      byp = model_bypass();
      vld = (q.size() > 0) || byp;
      pop = vld && !freeze;
      acc = fif.in_valid && (q.size() < DEPTH);
      e.ins = fif.instruction;
      e.pc  = fif.pc;
      if (acc) q.push_back(e);
      if (pop) void'(q.pop_front());
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [AW-1:0] p,
                       input logic frz, input logic fl, input logic rs);
    drive(iv, ins, p, frz, fl, rs, 1'b1);
    commit();
  endtask

  logic [31:0] fill_w [4] = '{32'hE3A01005, 32'hE2811001, 32'hE0822001, 32'hEAFFFFFE};

  initial begin
    // Reset then idle
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); commit();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0); commit();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fif.in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    commit();

    // Fill while frozen
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_w[i], AW'(4 * i), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(fif.in_ready), 64'd0);
    chk("head_cond", 64'(cond), 64'hE);
    chk("head_imm", 64'(imm), 64'd1);
    chk("head_opc", 64'(opCode), 64'hD);
    chk("head_rd", 64'(rd), 64'd1);
    chk("head_shop", 64'(shifterOpr), 64'h005);
    chk("head_pc", 64'(out_pc), 64'd0);
    commit();

    // Release freeze: drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("drain_pc", 64'(out_pc), 64'(4 * i));
      if (i == 3) chk("last_imm24", 64'(signedImm24), 64'hFFFFFE);
      commit();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drained_valid", 64'(out_valid), 64'd0);
    commit();

    // Simultaneous push/pop at count 2 across pointer wrap
    cycle(1'b1, 32'hE1A00001, 32'h100, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hE1A00002, 32'h104, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hE2800000 + 32'(i), AW'(32'h200 + 4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
      chk("stream_count", 64'(count), 64'd2);
      commit();
    end

    // Flush at count 3 with a simultaneous push and pop
    cycle(1'b1, 32'hE3A0F0AA, 32'h300, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 32'h400, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    commit();

    // Bypass / minimum latency
    drive(1'b1, 32'hE1A00000, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef IF_ID_QUEUE_BYPASS_EN
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_opc", 64'(opCode), 64'hD);
    commit();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_after_valid", 64'(out_valid), 64'd0);
`else
    chk("nobyp_valid", 64'(out_valid), 64'd0);
    commit();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("nobyp_late_valid", 64'(out_valid), 64'd1);
    chk("nobyp_opc", 64'(opCode), 64'hD);
    chk("nobyp_count", 64'(count), 64'd1);
`endif
    commit();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 60), $urandom, AW'($urandom),
            ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
